render_frame_scheduler: RTL and testbench
=========================================

Name: render_frame_scheduler

Overview:
- Sequences the full_renderer across the fixed 3D screen region: issues (hcount, vcount) coordinates over AXI-stream, tracks returned pixels, and generates framebuffer write addresses.
- Manages a double-buffered framebuffer. Writes go to the back bank; the VGA readout reads the front bank. Banks swap only on a frame boundary after a complete render.
- Sits between vga_sig_gen (frame_start_in) and full_renderer/renderer_buffer. Replaces the free-running renderer_sig_gen.

Parameters:
- START_X, 260, first region column (inclusive), 11 bits.
- START_Y, 195, first region row (inclusive), 10 bits.
- END_X, 390, region column end (exclusive).
- END_Y, 295, region row end (exclusive).
- ADDR_W, 14, per-bank pixel address width; must satisfy (END_X-START_X)*(END_Y-START_Y) <= 2^ADDR_W.

Ports:
- aclk  in  1  single clock domain.
- aresetn  in  1  asynchronous active-low reset.
- frame_start_in  in  1  one-cycle new-frame pulse (vga_sig_gen nf_out).
- coord_h_tdata  out  11  hcount issued to the renderer.
- coord_v_tdata  out  10  vcount issued to the renderer.
- coord_tvalid  out  1  coordinate valid.
- coord_tready  in  1  renderer accepts the coordinate.
- pix_tvalid  in  1  renderer output pixel valid (tready is tied 1 upstream).
- pix_hcount_in  in  11  renderer hcount_out.
- pix_vcount_in  in  10  renderer vcount_out.
- wr_en_out  out  1  framebuffer port-A write enable.
- wr_addr_out  out  ADDR_W+1  {wr_bank, offset}.
- rd_bank_out  out  1  front bank for readout (MSB of port-B address).
- busy_out  out  1  high in ISSUE or DRAIN.
- frame_done_out  out  1  one-cycle pulse when the last pixel is written.
- overrun_count_out  out  8  frames where frame_start arrived before the render completed; saturates at 255.
- range_err_out  out  1  sticky: a returned pixel fell outside the region.

Behaviour:
- Reset (async assert, sync deassert use):
  - state=IDLE; coord_tvalid=0; coord outputs = START_X/START_Y.
  - wr_en_out=0; wr_addr_out=0; rd_bank_out=0; internal wr_bank=1.
  - busy_out=0; frame_done_out=0; overrun_count_out=0; range_err_out=0; pixel counter=0; done flag=0.
- NUM_PIX = (END_X-START_X)*(END_Y-START_Y) = 13000 at defaults.
- States:
  - IDLE: on frame_start_in -> ISSUE. Coordinate = (START_X, START_Y). Pixel counter cleared.
  - ISSUE: coord_tvalid=1. On coord_tvalid & coord_tready, advance h. At h=END_X-1, wrap h to START_X and increment v. Handshake on (END_X-1, END_Y-1) -> DRAIN, coord_tvalid=0 the next cycle.
  - DRAIN: wait until the pixel counter reaches NUM_PIX, then -> READY and pulse frame_done_out.
  - READY: on frame_start_in, toggle rd_bank_out and wr_bank, then -> ISSUE for the next frame (back-to-back rendering).
- Coordinate data/valid are held stable until the handshake completes (AXI rule); no change while coord_tready=0.
- Pixel path, 1-cycle latency:
  - pix_tvalid with in-range coordinates -> next cycle wr_en_out=1.
  - wr_addr_out = {wr_bank, (h-START_X)+(v-START_Y)*(END_X-START_X)}, computed at ADDR_W bits.
  - The counter increments on the same cycle the write is registered.
- Out-of-range pixel (h<START_X, h>=END_X, v<START_Y or v>=END_Y): no write, no count, range_err_out set sticky until reset.
- frame_start_in in ISSUE or DRAIN: overrun_count_out++ (saturating). No swap; rendering continues into the same back bank.
- frame_start_in on the same cycle the final pixel write completes the count: treated as complete. Swap and restart ISSUE that cycle; no overrun; frame_done_out still pulses.
- frame_start_in in IDLE only starts a render; no swap.
- pix_tvalid outside ISSUE/DRAIN: writes are still honoured (address rule above) but not counted.
- Reset mid-render: all state cleared immediately; framebuffer contents are not touched.

Decomposition:
- Shared package render_pkg:
  - typedef hcount_t (11 b), vcount_t (10 b);
  - region constants START_X/START_Y/END_X/END_Y;
  - state enum sched_state_t {IDLE, ISSUE, DRAIN, READY}.
- One sub-module: region_addr_gen. Registered range check plus (h,v)->offset multiply-add with 1-cycle latency. It is reused by the readout-side address logic.

Test Plan:
- Reset, then a frame_start pulse with coord_tready=1 -> first beats (260,195),(261,195); after 130 beats (260,196); the last beat is (389,294) at beat 13000; coord_tvalid then drops.
- coord_tready toggled randomly -> coord data stable while stalled; exactly 13000 handshakes; no skipped or duplicated coordinate.
- Loop the renderer with a fixed 50-cycle delay -> wr_addr_out sequence {1,0..12999}; frame_done_out one pulse after the 13000th write; the next frame_start gives rd_bank_out=1 and wr_addr MSB=0.
- frame_start during DRAIN (renderer stalled) -> overrun_count_out=1, rd_bank_out unchanged; 256 such frames -> count stays 255.
- Inject pix (100,50) -> no wr_en_out, range_err_out=1 persists; the counter is unaffected.
- aresetn asserted mid-ISSUE -> outputs take their reset values asynchronously in the same cycle; the next frame_start restarts at (260,195) with rd_bank_out=0.

Source files
------------

// File: rtl/render_pkg.sv
// Shared types and region constants for the render frame scheduler.
package render_pkg;

  typedef logic [10:0] hcount_t;
  typedef logic [9:0]  vcount_t;

  // Default 3D screen region: columns [START_X, END_X), rows [START_Y, END_Y)
  localparam int START_X = 260;
  localparam int START_Y = 195;
  localparam int END_X   = 390;
  localparam int END_Y   = 295;
  localparam int ADDR_W  = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    READY = 2'd3
  } sched_state_t;

  // Number of pixels in a rectangular region
  function automatic int region_pixels(input int sx, input int sy, input int ex, input int ey);
    return (ex - sx) * (ey - sy);
  endfunction

endpackage

// File: rtl/region_addr_gen.sv
// Registered region range check and (h,v) -> linear offset conversion.
// One cycle of latency; a sideband tag travels with the pixel so callers
// can attach bank/bookkeeping bits that line up with the result.
module region_addr_gen #(
  parameter int START_X = 260,
  parameter int START_Y = 195,
  parameter int END_X   = 390,
  parameter int END_Y   = 295,
  parameter int ADDR_W  = 14,
  parameter int TAG_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  render_pkg::hcount_t   h_in,
  input  render_pkg::vcount_t   v_in,
  input  logic [TAG_W-1:0]      tag_in,
  output logic                  valid_out,
  output logic                  err_out,
  output logic [TAG_W-1:0]      tag_out,
  output logic [ADDR_W-1:0]     offset_out
);

  logic              in_range;
  logic [ADDR_W-1:0] h_off;
  logic [ADDR_W-1:0] v_off;
  logic [ADDR_W-1:0] offset_next;

  // Range test and row-major offset; offset is only meaningful when in range
  always_comb begin
    in_range    = (int'(h_in) >= START_X) && (int'(h_in) < END_X) &&
                  (int'(v_in) >= START_Y) && (int'(v_in) < END_Y);
    h_off       = ADDR_W'(h_in) - ADDR_W'(START_X);
    v_off       = ADDR_W'(v_in) - ADDR_W'(START_Y);
    offset_next = h_off + v_off * ADDR_W'(END_X - START_X);
  end

  // Output register: valid only for in-range pixels, err for out-of-range ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out  <= 1'b0;
      err_out    <= 1'b0;
      tag_out    <= '0;
      offset_out <= '0;
    end else begin
      valid_out  <= valid_in & in_range;
      err_out    <= valid_in & ~in_range;
      tag_out    <= tag_in;
      offset_out <= offset_next;
    end
  end

endmodule

// File: rtl/render_frame_scheduler.sv
// Frame scheduler: issues region coordinates to the renderer, converts the
// returned pixels to framebuffer writes and flips the double buffer on
// frame boundaries once a render has fully landed.
module render_frame_scheduler #(
  parameter int START_X = render_pkg::START_X,
  parameter int START_Y = render_pkg::START_Y,
  parameter int END_X   = render_pkg::END_X,
  parameter int END_Y   = render_pkg::END_Y,
  parameter int ADDR_W  = render_pkg::ADDR_W
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 frame_start_in,
  output render_pkg::hcount_t  coord_h_tdata,
  output render_pkg::vcount_t  coord_v_tdata,
  output logic                 coord_tvalid,
  input  logic                 coord_tready,
  input  logic                 pix_tvalid,
  input  render_pkg::hcount_t  pix_hcount_in,
  input  render_pkg::vcount_t  pix_vcount_in,
  output logic                 wr_en_out,
  output logic [ADDR_W:0]      wr_addr_out,
  output logic                 rd_bank_out,
  output logic                 busy_out,
  output logic                 frame_done_out,
  output logic [7:0]           overrun_count_out,
  output logic                 range_err_out
);

  import render_pkg::*;

  localparam int              NUM_PIX   = region_pixels(START_X, START_Y, END_X, END_Y);
  localparam logic [ADDR_W:0] NUM_PIX_C = (ADDR_W+1)'(NUM_PIX);
  localparam logic [ADDR_W:0] LAST_C    = (ADDR_W+1)'(NUM_PIX - 1);
  localparam hcount_t         H_FIRST   = hcount_t'(START_X);
  localparam hcount_t         H_LAST    = hcount_t'(END_X - 1);
  localparam vcount_t         V_FIRST   = vcount_t'(START_Y);
  localparam vcount_t         V_LAST    = vcount_t'(END_Y - 1);

  sched_state_t      state;
  sched_state_t      state_next;
  logic              wr_bank;
  logic [ADDR_W:0]   pix_count;
  logic              beat;
  logic              last_beat;
  logic              counting;
  logic              count_wr;
  logic              last_write;
  logic              render_done;
  logic              swap;
  logic              overrun;
  logic              restart;
  logic              gen_err;
  logic [1:0]        gen_tag;
  logic [ADDR_W-1:0] gen_offset;

  // Handshake, completion and frame-boundary decisions
  always_comb begin
    beat        = (state == ISSUE) & coord_tready;
    last_beat   = beat & (coord_h_tdata == H_LAST) & (coord_v_tdata == V_LAST);
    counting    = (state == ISSUE) | (state == DRAIN);
    // gen_tag[0]: pixel entered while a render was active, so it counts
    count_wr    = wr_en_out & gen_tag[0] & (pix_count != NUM_PIX_C);
    last_write  = count_wr & (pix_count == LAST_C);
    // A frame start landing on the completing write still counts as complete
    render_done = (pix_count == NUM_PIX_C) | last_write;
    swap        = frame_start_in & ((state == READY) | ((state == DRAIN) & render_done));
    overrun     = frame_start_in & ((state == ISSUE) | ((state == DRAIN) & ~render_done));
    restart     = (state_next == ISSUE) & (state != ISSUE);
  end

  // Pixel path: range check and offset, tagged with the bank and count flag
  region_addr_gen #(
    .START_X (START_X),
    .START_Y (START_Y),
    .END_X   (END_X),
    .END_Y   (END_Y),
    .ADDR_W  (ADDR_W),
    .TAG_W   (2)
  ) u_addr_gen (
    .clk        (aclk),
    .rst_n      (aresetn),
    .valid_in   (pix_tvalid),
    .h_in       (pix_hcount_in),
    .v_in       (pix_vcount_in),
    .tag_in     ({wr_bank, counting}),
    .valid_out  (wr_en_out),
    .err_out    (gen_err),
    .tag_out    (gen_tag),
    .offset_out (gen_offset)
  );

  assign wr_addr_out = {gen_tag[1], gen_offset};

  // FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_next;
  end

  // FSM next state and state-decoded outputs
  always_comb begin
    state_next   = state;
    coord_tvalid = 1'b0;
    busy_out     = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start_in) state_next = ISSUE;
      end
      ISSUE: begin
        coord_tvalid = 1'b1;
        busy_out     = 1'b1;
        if (last_beat) state_next = DRAIN;
      end
      DRAIN: begin
        busy_out = 1'b1;
        if (render_done) state_next = frame_start_in ? ISSUE : READY;
      end
      READY: begin
        if (frame_start_in) state_next = ISSUE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Coordinate raster: advance only on a handshake, wrap at the region edges
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      coord_h_tdata <= H_FIRST;
      coord_v_tdata <= V_FIRST;
    end else if (restart) begin
      coord_h_tdata <= H_FIRST;
      coord_v_tdata <= V_FIRST;
    end else if (beat) begin
      if (coord_h_tdata == H_LAST) begin
        coord_h_tdata <= H_FIRST;
        coord_v_tdata <= (coord_v_tdata == V_LAST) ? V_FIRST : coord_v_tdata + 10'd1;
      end else begin
        coord_h_tdata <= coord_h_tdata + 11'd1;
      end
    end
  end

  // Written-pixel counter for the render in progress
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)      pix_count <= '0;
    else if (restart)  pix_count <= '0;
    else if (count_wr) pix_count <= pix_count + 1'b1;
  end

  // Bank flip, overrun tally, sticky range error and done pulse
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_bank_out       <= 1'b0;
      wr_bank           <= 1'b1;
      overrun_count_out <= 8'd0;
      range_err_out     <= 1'b0;
      frame_done_out    <= 1'b0;
    end else begin
      if (swap) begin
        rd_bank_out <= ~rd_bank_out;
        wr_bank     <= ~wr_bank;
      end
      if (overrun && (overrun_count_out != 8'd255))
        overrun_count_out <= overrun_count_out + 8'd1;
      if (gen_err) range_err_out <= 1'b1;
      frame_done_out <= last_write;
    end
  end

endmodule

// File: tb/tb_render_frame_scheduler.sv
// Randomized scoreboard bench for render_frame_scheduler with a delayed
// renderer loopback and a frame-level reference model.
module tb_render_frame_scheduler;

  localparam int SX    = 260;
  localparam int SY    = 195;
  localparam int EX    = 390;
  localparam int EY    = 295;
  localparam int W     = EX - SX;
  localparam int NUM   = W * (EY - SY);
  localparam int AW    = 14;
  localparam int DELAY = 50;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        frame_start_in;
  logic [10:0] coord_h_tdata;
  logic [9:0]  coord_v_tdata;
  logic        coord_tvalid;
  logic        coord_tready;
  logic        pix_tvalid;
  logic [10:0] pix_hcount_in;
  logic [9:0]  pix_vcount_in;
  logic        wr_en_out;
  logic [AW:0] wr_addr_out;
  logic        rd_bank_out;
  logic        busy_out;
  logic        frame_done_out;
  logic [7:0]  overrun_count_out;
  logic        range_err_out;

  render_frame_scheduler dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .frame_start_in    (frame_start_in),
    .coord_h_tdata     (coord_h_tdata),
    .coord_v_tdata     (coord_v_tdata),
    .coord_tvalid      (coord_tvalid),
    .coord_tready      (coord_tready),
    .pix_tvalid        (pix_tvalid),
    .pix_hcount_in     (pix_hcount_in),
    .pix_vcount_in     (pix_vcount_in),
    .wr_en_out         (wr_en_out),
    .wr_addr_out       (wr_addr_out),
    .rd_bank_out       (rd_bank_out),
    .busy_out          (busy_out),
    .frame_done_out    (frame_done_out),
    .overrun_count_out (overrun_count_out),
    .range_err_out     (range_err_out)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_REND, M_READY} mst_t;
  mst_t m_st;
  int   m_rd, m_bank, m_ovr, m_rerr, m_count, m_last_cyc;

  int coord_q[$];   // expected beats, h*1024+v
  int wr_q[$];      // expected write addresses
  int done_q[$];    // expected cycle of frame_done pulse

  typedef struct {int h; int v; int due;} pend_t;
  pend_t pipe_q[$]; // renderer in-flight coordinates
  int    inj_q[$];  // extra pixels to inject, h*1024+v
  bit    hold = 1'b0;
  bit    rand_ready = 1'b0;
  bit    pv = 1'b0, pr = 1'b0;
  int    ph = 0, pvv = 0;

  task automatic model_reset();
    m_st = M_IDLE; m_rd = 0; m_bank = 1; m_ovr = 0; m_rerr = 0;
    m_count = 0; m_last_cyc = -10;
    coord_q.delete(); wr_q.delete(); done_q.delete();
    pipe_q.delete(); inj_q.delete();
    pv = 1'b0;
  endtask

  task automatic start_render();
    m_count = 0;
    m_st = M_REND;
    for (int k = 0; k < NUM; k++)
      coord_q.push_back((SX + k % W) * 1024 + (SY + k / W));
  endtask

  task automatic model_frame_start();
    if (m_st == M_IDLE) begin
      start_render();
    end else if (m_st == M_READY && m_last_cyc < cyc) begin
      m_rd = 1 - m_rd;
      m_bank = 1 - m_bank;
      start_render();
    end else begin
      if (m_ovr < 255) m_ovr++;
    end
  endtask

  task automatic model_pix(input int h, input int v);
    if (h >= SX && h < EX && v >= SY && v < EY) begin
      wr_q.push_back(m_bank * (2 ** AW) + (h - SX) + (v - SY) * W);
      if (m_st == M_REND && m_count < NUM) begin
        m_count++;
        if (m_count == NUM) begin
          m_st = M_READY;
          m_last_cyc = cyc;
          done_q.push_back(cyc + 2);
        end
      end
    end else begin
      m_rerr = 1;
    end
  endtask

  // ---------------- renderer emulation ----------------
  initial begin
    coord_tready = 1'b0;
    pix_tvalid = 1'b0;
    pix_hcount_in = '0;
    pix_vcount_in = '0;
    forever begin
      @(negedge aclk);
      coord_tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (coord_tvalid && coord_tready)
        pipe_q.push_back('{int'(coord_h_tdata), int'(coord_v_tdata), cyc + DELAY});
      pix_tvalid = 1'b0;
      if (inj_q.size() > 0) begin
        int e;
        e = inj_q.pop_front();
        pix_tvalid = 1'b1;
        pix_hcount_in = 11'(e / 1024);
        pix_vcount_in = 10'(e % 1024);
        model_pix(e / 1024, e % 1024);
      end else if (!hold && pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
        pend_t p;
        p = pipe_q.pop_front();
        pix_tvalid = 1'b1;
        pix_hcount_in = 11'(p.h);
        pix_vcount_in = 10'(p.v);
        model_pix(p.h, p.v);
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge aclk);
      #1;
      if (aresetn && pv && !pr)
        chk("coord_stable", {coord_tvalid, coord_h_tdata, coord_v_tdata},
            {1'b1, 11'(ph), 10'(pvv)});
      if (coord_tvalid && coord_tready) begin
        if (coord_q.size() == 0) fail("coord_extra_beat");
        else chk("coord_beat", int'(coord_h_tdata) * 1024 + int'(coord_v_tdata), coord_q.pop_front());
      end
      pv = coord_tvalid; pr = coord_tready;
      ph = int'(coord_h_tdata); pvv = int'(coord_v_tdata);
      if (wr_en_out) begin
        if (wr_q.size() == 0) fail("wr_unexpected");
        else chk("wr_addr", wr_addr_out, wr_q.pop_front());
      end
      if (frame_done_out) begin
        if (done_q.size() == 0) fail("frame_done_unexpected");
        else chk("frame_done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  // ---------------- main sequence ----------------
  task automatic pulse_frame_start();
    frame_start_in = 1'b1;
    model_frame_start();
    @(negedge aclk);
    frame_start_in = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_tvalid"},  coord_tvalid, 0);
    chk({tag, "_h"},       coord_h_tdata, SX);
    chk({tag, "_v"},       coord_v_tdata, SY);
    chk({tag, "_wr_en"},   wr_en_out, 0);
    chk({tag, "_wr_addr"}, wr_addr_out, 0);
    chk({tag, "_rd_bank"}, rd_bank_out, 0);
    chk({tag, "_busy"},    busy_out, 0);
    chk({tag, "_done"},    frame_done_out, 0);
    chk({tag, "_overrun"}, overrun_count_out, 0);
    chk({tag, "_rerr"},    range_err_out, 0);
  endtask

  task automatic wait_ready(input string name, input int bound);
    int n = 0;
    while (m_st != M_READY && n < bound) begin @(negedge aclk); n++; end
    if (m_st != M_READY) fail(name);
  endtask

  initial begin
    int n;
    aresetn = 1'b0;
    frame_start_in = 1'b0;
    model_reset();
    repeat (3) @(negedge aclk);
    reset_checks("reset");
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // Frame 1: always-ready renderer, out-of-range pixels injected mid-frame
    pulse_frame_start();
    chk("f1_busy", busy_out, 1);
    chk("f1_tvalid", coord_tvalid, 1);
    chk("f1_rd_bank", rd_bank_out, m_rd);
    n = 0;
    while (coord_q.size() > NUM - 1000 && n < 5000) begin @(negedge aclk); n++; end
    if (n >= 5000) fail("f1_timeout_beats");
    inj_q.push_back(100 * 1024 + 50);
    inj_q.push_back(390 * 1024 + 200);
    inj_q.push_back(259 * 1024 + 294);
    inj_q.push_back(300 * 1024 + 295);
    wait_ready("f1_timeout_done", 20000);
    chk("f1_range_err", range_err_out, m_rerr);
    chk("f1_overrun", overrun_count_out, m_ovr);

    // Frame start on the completing write: swap, restart, no overrun
    if (cyc == m_last_cyc) @(negedge aclk);
    pulse_frame_start();
    chk("f2_rd_bank", rd_bank_out, m_rd);
    chk("f2_overrun", overrun_count_out, m_ovr);
    chk("f2_busy", busy_out, 1);
    n = 0;
    while (coord_q.size() > NUM - 2000 && n < 5000) begin @(negedge aclk); n++; end
    if (n >= 5000) fail("f2_timeout_beats");

    // Reset in the middle of ISSUE
    #2;
    aresetn = 1'b0;
    model_reset();
    #1;
    reset_checks("midreset");
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // Frame 3: random tready, renderer stalls in DRAIN, overruns
    rand_ready = 1'b1;
    pulse_frame_start();
    chk("f3_rd_bank", rd_bank_out, m_rd);
    n = 0;
    while (coord_q.size() > 0 && n < 40000) begin @(negedge aclk); n++; end
    if (n >= 40000) fail("f3_timeout_beats");
    hold = 1'b1;
    repeat (3) @(negedge aclk);
    chk("f3_drain_tvalid", coord_tvalid, 0);
    chk("f3_drain_busy", busy_out, 1);
    pulse_frame_start();
    chk("f3_overrun_one", overrun_count_out, m_ovr);
    chk("f3_rd_bank_kept", rd_bank_out, m_rd);
    for (int i = 0; i < 256; i++) begin
      pulse_frame_start();
      @(negedge aclk);
    end
    chk("f3_overrun_sat", overrun_count_out, m_ovr);
    chk("f3_rd_bank_kept2", rd_bank_out, m_rd);
    hold = 1'b0;
    wait_ready("f3_timeout_done", 2000);
    repeat (3) @(negedge aclk);
    chk("f3_ready_busy", busy_out, 0);
    chk("f3_ready_tvalid", coord_tvalid, 0);

    // Pixels outside a render: in-range one is written, not counted
    inj_q.push_back(300 * 1024 + 200);
    inj_q.push_back(259 * 1024 + 200);
    repeat (5) @(negedge aclk);
    chk("end_range_err", range_err_out, m_rerr);
    chk("end_overrun", overrun_count_out, m_ovr);
    chk("end_wr_pending", wr_q.size(), 0);
    chk("end_coord_pending", coord_q.size(), 0);
    chk("end_done_pending", done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
